stream_demux6: RTL and testbench
================================

Name: stream_demux6

Overview:
- Reverse direction of the 6-way data selector: one valid/ready input stream is routed, beat by beat, to one of six output channels chosen by a 3-bit sel.
- Each output channel has a one-entry holding register with its own valid/ready handshake, so a slow consumer stalls only beats addressed to it.
- Beats addressed to sel values 6 and 7 are consumed and discarded, then flagged.
- Sits between a producer and six per-lane consumers in the datapath.

Parameters:
- WIDTH, 4, bit width of the data payload on input and on every output channel.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat is accepted this cycle when in_valid && in_ready.
- sel  input  3  destination channel for the current input beat; sampled with the beat.
- in_data  input  WIDTH  payload.
- out_valid  output  6  bit k set: out_data<k> holds a beat.
- out_ready  input  6  bit k set: consumer k takes its beat this cycle.
- out_data0 .. out_data5  output  WIDTH each  per-channel payload registers.
- sel_err  output  1  one-cycle pulse, the cycle after a beat with sel >= 6 is accepted.

Behaviour:
- Reset, synchronous and active-high; reset has priority over every other event:
  - out_valid = 6'b0.
  - out_data0..5 = 0.
  - sel_err = 0.
  - An in-flight beat accepted in the same cycle as reset is lost.
- in_ready is combinational from sel, out_valid and out_ready only, never from in_valid:
  - sel in 0..5: in_ready = !out_valid[sel] || out_ready[sel].
  - sel in 6..7: in_ready = 1.
- Accept with sel = k, k in 0..5:
  - Next edge loads out_data<k> = in_data and sets out_valid[k] = 1.
  - Latency is one cycle, input to output valid.
- Drain: out_valid[k] && out_ready[k] with no load to channel k clears out_valid[k]. out_data<k> keeps its stale value.
- Simultaneous drain and load on the same channel: out_data<k> takes the new beat, out_valid[k] stays 1. Full throughput is one beat per cycle per channel.
- out_ready[j] for a channel that is not being loaded only affects channel j. Channels are fully independent.
- Accept with sel = 6 or 7: the beat is discarded, no channel changes, and sel_err = 1 for exactly one cycle. Back-to-back bad beats give sel_err held high for consecutive cycles.
- A full channel with out_ready = 0 holds in_ready = 0 while sel points at it. The producer must keep in_valid, sel and in_data stable until accepted.
- out_data<k> must not change while out_valid[k] && !out_ready[k].
- No combinational path from out_ready to out_data or out_valid.

Optional Feature:
- Macro STREAM_DEMUX_DROP_CNT_EN.
- Defined: adds output drop_cnt, 8 bits.
  - Increments on every accepted beat with sel >= 6.
  - Saturates at 255.
  - Resets to 0.
- Undefined: drop_cnt port and logic are absent; sel_err behaviour is unchanged.

Decomposition:
- Package stream_demux_pkg holds:
  - Constants NUM_CH = 6 and SEL_W = 3.
  - typedef sel_t, which is logic [SEL_W-1:0].
  - Function sel_in_range(sel_t).
- Sub-module demux_slot: the one-entry register with valid/ready, load and drain, and WIDTH parameter. It is instantiated six times. The top level holds the in_ready mux, load decode and error logic.

Test Plan:
- Reset, then in_valid = 1, sel = 2, in_data = 4'hA, all out_ready = 0 -> in_ready = 1; next cycle out_valid = 6'b000100, out_data2 = 4'hA, sel_err = 0.
- Channel 2 full, out_ready[2] = 0, present sel = 2, in_data = 4'h5 -> in_ready = 0, out_data2 stays 4'hA. Raise out_ready[2] -> in_ready = 1; next cycle out_data2 = 4'h5 and out_valid[2] = 1 (drain and reload in the same cycle).
- Stream sel = 0,1,2,3,4,5 with data 1..6, one per cycle, all out_ready = 1 -> each channel pulses out_valid for one cycle with its data; no stall.
- Present sel = 6 then sel = 7, in_data = 4'hF -> in_ready = 1 both cycles; sel_err high for two consecutive cycles; out_valid unchanged. With the macro defined, drop_cnt = 2.
- Load channels 0 and 5 and hold out_ready = 0, then assert reset for one cycle while in_valid = 1 and sel = 3 -> after the edge out_valid = 0, all out_data = 0, sel_err = 0, drop_cnt = 0.
- With the macro defined, send 260 beats with sel = 7 -> drop_cnt stops at 255.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream_demux6 slice.
//   NUM_CH       : number of real output channels (6)
//   SEL_W        : width of the channel select (3)
//   sel_t        : channel select type
//   sel_in_range : true when a select value addresses a real channel
package stream_demux_pkg;

  localparam int NUM_CH = 6;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_LAST = sel_t'(NUM_CH - 1);

  function automatic logic sel_in_range(sel_t s);
    return (s <= SEL_LAST);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with a valid/ready output handshake.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load         : capture load_data this edge (caller guarantees the slot is
//                  empty or being drained in the same cycle)
//   load_data    : payload to capture
//   drain_ready  : consumer takes the held beat this cycle
//   valid, data  : registered slot state
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      // A load wins over a drain: the old beat leaves, the new one lands.
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (r_valid && drain_ready) begin
      // Data is left stale on purpose; only valid matters once drained.
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule

// File: rtl/stream_demux6.sv
// Routes one valid/ready input stream to one of six output channels chosen
// by sel. Each channel is a one-entry register, so a stalled consumer only
// blocks beats addressed to it. Beats with sel 6 or 7 are swallowed and
// reported on sel_err one cycle later.
// Optional build macro: STREAM_DEMUX_DROP_CNT_EN adds an 8-bit saturating
// drop_cnt output counting swallowed beats.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   in_valid/in_ready        : input handshake (in_ready never depends on in_valid)
//   sel, in_data             : destination and payload of the input beat
//   out_valid/out_ready [5:0]: per-channel output handshake
//   out_data0..out_data5     : per-channel payload registers
//   sel_err                  : one-cycle pulse after an out-of-range beat is accepted
//   drop_cnt                 : (macro only) saturating count of dropped beats
module stream_demux6
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        sel,
  input  logic [WIDTH-1:0]  in_data,
  output logic [5:0]        out_valid,
  input  logic [5:0]        out_ready,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3,
  output logic [WIDTH-1:0]  out_data4,
  output logic [WIDTH-1:0]  out_data5,
  output logic              sel_err
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  logic [NUM_CH-1:0] w_slot_free;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_valid;
  logic [WIDTH-1:0]  w_data [NUM_CH];
  logic              w_sel_ok;
  logic              w_in_ready;
  logic              w_accept;
  logic              r_sel_err;

  assign w_sel_ok = sel_in_range(sel);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // A slot can take a beat when empty or when its current beat leaves now.
      assign w_slot_free[gi] = !w_valid[gi] || out_ready[gi];
      assign w_load[gi]      = w_accept && (sel == sel_t'(gi));

      demux_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load[gi]),
        .load_data  (in_data),
        .drain_ready(out_ready[gi]),
        .valid      (w_valid[gi]),
        .data       (w_data[gi])
      );
    end
  endgenerate

  // Out-of-range selects are always accepted (and discarded).
  always_comb begin
    w_in_ready = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == sel_t'(k)) begin
        w_in_ready = w_slot_free[k];
      end
    end
  end

  assign w_accept = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_accept && !w_sel_ok;
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_accept && !w_sel_ok && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_valid;
  assign sel_err   = r_sel_err;
  assign out_data0 = w_data[0];
  assign out_data1 = w_data[1];
  assign out_data2 = w_data[2];
  assign out_data3 = w_data[3];
  assign out_data4 = w_data[4];
  assign out_data5 = w_data[5];

endmodule

// File: tb/tb_stream_demux6.sv
// Self-checking bench for stream_demux6. Directed scenario tasks check exact
// values inline; a negedge monitor keeps a per-channel queue of expected
// beats (pushed on accept, popped on drain) and an expected sel_err/drop_cnt.
module tb_stream_demux6;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [3:0] in_data;
  logic [5:0] out_valid;
  logic [5:0] out_ready;
  logic [3:0] od [6];
  logic       sel_err;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [3:0] q [6][$];
  logic       exp_err = 1'b0;
  int         exp_drop = 0;

  always #5 clk = ~clk;

  stream_demux6 #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data0(od[0]),
    .out_data1(od[1]),
    .out_data2(od[2]),
    .out_data3(od[3]),
    .out_data4(od[4]),
    .out_data5(od[5]),
    .sel_err  (sel_err)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  // Scoreboard monitor: compare, then advance the expected state using the
  // handshake values that will be sampled at the coming rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (sel_err !== exp_err) begin
        errors++;
        $display("FAIL mon_sel_err: got %b want %b at %0t", sel_err, exp_err, $time);
      end
`ifdef STREAM_DEMUX_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 8'(exp_drop)) begin
        errors++;
        $display("FAIL mon_drop_cnt: got %0d want %0d at %0t", drop_cnt, exp_drop, $time);
      end
`endif
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (out_valid[k] !== (q[k].size() != 0)) begin
          errors++;
          $display("FAIL mon_valid%0d: got %b want %b at %0t", k, out_valid[k], q[k].size() != 0, $time);
        end else if (q[k].size() != 0) begin
          checks++;
          if (od[k] !== q[k][0]) begin
            errors++;
            $display("FAIL mon_data%0d: got %h want %h at %0t", k, od[k], q[k][0], $time);
          end
        end
        if (out_valid[k] && out_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
      end
      if (reset) begin
        for (int k = 0; k < 6; k++) q[k].delete();
        exp_err  = 1'b0;
        exp_drop = 0;
      end else begin
        exp_err = in_valid && in_ready && (sel >= 3'd6);
        if (in_valid && in_ready) begin
          if (sel < 3'd6) begin
            q[sel].push_back(in_data);
            $display("accept sel=%0d data=%h t=%0t", sel, in_data, $time);
          end else begin
            if (exp_drop < 255) exp_drop++;
            $display("drop sel=%0d data=%h t=%0t", sel, in_data, $time);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; sel = 3'd0; in_data = 4'h0; out_ready = 6'b0;
    step(); step();
    mon_en = 1'b1;
    checks++;
    if (out_valid !== 6'b0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b err=%b want valid=000000 err=0", out_valid, sel_err);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (od[k] !== 4'h0) begin
        errors++;
        $display("FAIL reset_data%0d: got %h want 0", k, od[k]);
      end
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop: got %0d want 0", drop_cnt);
    end
`endif
    reset = 1'b0;
    step();
  endtask

  task automatic test_load_stall_reload();
    in_valid = 1'b1; sel = 3'd2; in_data = 4'hA; out_ready = 6'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", in_ready); end
    step();
    checks++;
    if (out_valid !== 6'b000100 || od[2] !== 4'hA || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL load_out: got valid=%b d2=%h err=%b want 000100 A 0", out_valid, od[2], sel_err);
    end
    in_data = 4'h5;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    step();
    checks++;
    if (od[2] !== 4'hA || out_valid !== 6'b000100) begin
      errors++;
      $display("FAIL stall_hold: got valid=%b d2=%h want 000100 A", out_valid, od[2]);
    end
    out_ready = 6'b000100;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (od[2] !== 4'h5 || out_valid !== 6'b000100) begin
      errors++;
      $display("FAIL reload_out: got valid=%b d2=%h want 000100 5", out_valid, od[2]);
    end
    step();
    out_ready = 6'b0;
    checks++;
    if (out_valid !== 6'b0) begin errors++; $display("FAIL drain_clear: got %b want 000000", out_valid); end
  endtask

  task automatic test_stream_all();
    out_ready = 6'b111111;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; sel = 3'(i); in_data = 4'(i + 1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); end
      step();
      checks++;
      if (out_valid !== (6'b1 << i) || od[i] !== 4'(i + 1)) begin
        errors++;
        $display("FAIL stream_out%0d: got valid=%b data=%h want %b %h", i, out_valid, od[i], 6'b1 << i, 4'(i + 1));
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 6'b0;
    checks++;
    if (out_valid !== 6'b0) begin errors++; $display("FAIL stream_end: got %b want 000000", out_valid); end
  endtask

  task automatic test_bad_sel();
    out_ready = 6'b0;
    in_valid = 1'b1; sel = 3'd1; in_data = 4'h9;
    step();
    for (int i = 0; i < 2; i++) begin
      sel = (i == 0) ? 3'd6 : 3'd7; in_data = 4'hF;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bad_ready%0d: got %b want 1", i, in_ready); end
      step();
      checks++;
      if (sel_err !== 1'b1 || out_valid !== 6'b000010 || od[1] !== 4'h9) begin
        errors++;
        $display("FAIL bad_err%0d: got err=%b valid=%b d1=%h want 1 000010 9", i, sel_err, out_valid, od[1]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (sel_err !== 1'b0) begin errors++; $display("FAIL bad_err_end: got %b want 0", sel_err); end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd2) begin errors++; $display("FAIL bad_drop: got %0d want 2", drop_cnt); end
`endif
    out_ready = 6'b111111;
    step();
    out_ready = 6'b0;
  endtask

  task automatic test_reset_inflight();
    out_ready = 6'b0;
    in_valid = 1'b1; sel = 3'd0; in_data = 4'h3; step();
    sel = 3'd5; in_data = 4'hC; step();
    checks++;
    if (out_valid !== 6'b100001) begin errors++; $display("FAIL pre_reset: got %b want 100001", out_valid); end
    sel = 3'd3; in_data = 4'h7; reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    step();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 6'b0 || sel_err !== 1'b0 || od[0] !== 4'h0 || od[3] !== 4'h0 || od[5] !== 4'h0) begin
      errors++;
      $display("FAIL rst_flush: got valid=%b err=%b d0=%h d3=%h d5=%h want all 0", out_valid, sel_err, od[0], od[3], od[5]);
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
`endif
    step();
    checks++;
    if (out_valid !== 6'b0) begin errors++; $display("FAIL rst_lost: got %b want 000000", out_valid); end
  endtask

  task automatic test_drop_saturate();
`ifdef STREAM_DEMUX_DROP_CNT_EN
    in_valid = 1'b1; sel = 3'd7; in_data = 4'h1;
    for (int i = 0; i < 260; i++) begin
      step();
      if (i == 254) begin
        checks++;
        if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d want 255", drop_cnt); end
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", drop_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      out_ready = 6'($urandom_range(0, 63));
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        sel = 3'($urandom_range(0, 7));
        in_data = 4'($urandom_range(0, 15));
      end
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 6'b111111;
    step();
    checks++;
    if (out_valid !== 6'b0) begin errors++; $display("FAIL b2b_drain: got %b want 000000", out_valid); end
    out_ready = 6'b0;
  endtask

  initial begin
    test_reset();
    test_load_stall_reload();
    test_stream_all();
    test_bad_sel();
    test_reset_inflight();
    test_drop_saturate();
    test_back_to_back();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
